// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) arithmetic helper.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  localparam int AES_NB_BYTES = 16;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_RUN,
    SB_DONE
  } sb_fsm_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic aes_byte_t gf_mul(aes_byte_t a, aes_byte_t b);
    aes_byte_t acc;
    aes_byte_t x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/sub_bytes_stage_if.sv
// Handshake bundle of the SubBytes stage: state in, substituted state out, busy flag.
interface sub_bytes_stage_if;
  import aes_pkg::*;

  logic       valid_i;
  logic       ready_o;
  aes_state_t state_i;
  logic       valid_o;
  logic       ready_i;
  aes_state_t state_o;
  logic       busy_o;

  modport slave (
    input  valid_i,
    input  state_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output state_o,
    output busy_o
  );

  modport master (
    output valid_i,
    output state_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  state_o,
    input  busy_o
  );

endinterface

// File: rtl/SubByte.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module SubByte
  import aes_pkg::*;
(
  input  aes_byte_t byte_i,
  output aes_byte_t byte_o
);

  aes_byte_t sq;
  aes_byte_t inv;

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires.
  always_comb begin
    sq  = byte_i;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    byte_o = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;
  end

endmodule

// File: rtl/sub_bytes_stage.sv
// Sequential AES SubBytes stage: substitutes the 16 state bytes LANES at a time, in place.
module sub_bytes_stage
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  sub_bytes_stage_if.slave bus
);

  localparam int unsigned Groups = AES_NB_BYTES / LANES;
  localparam int unsigned CntW   = (Groups > 1) ? $clog2(Groups) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gen_lanes_chk
    $error("sub_bytes_stage: LANES must be 1, 2, 4, 8 or 16");
  end

  sb_fsm_e               fsm_q;
  logic [CntW-1:0]       cnt_q;
  logic [15:0][7:0]      work_q;

  logic [3:0]            lane_idx [LANES];
  aes_byte_t             lane_in  [LANES];
  aes_byte_t             lane_out [LANES];

  // Lane j handles byte cnt*LANES+j of the current group.
  for (genvar j = 0; j < LANES; j++) begin : gen_lane
    assign lane_idx[j] = 4'(int'(cnt_q) * int'(LANES) + j);
    assign lane_in[j]  = work_q[lane_idx[j]];

    SubByte u_sbox (
      .byte_i (lane_in[j]),
      .byte_o (lane_out[j])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q  <= SB_IDLE;
      cnt_q  <= '0;
      work_q <= '0;
    end else begin
      case (fsm_q)
        SB_IDLE: begin
          if (bus.valid_i) begin
            work_q <= bus.state_i;
            cnt_q  <= '0;
            fsm_q  <= SB_RUN;
          end
        end
        SB_RUN: begin
          for (int j = 0; j < int'(LANES); j++) begin
            work_q[lane_idx[j]] <= lane_out[j];
          end
          if (cnt_q == CntW'(Groups - 1)) begin
            cnt_q <= '0;
            fsm_q <= SB_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SB_DONE: begin
          if (bus.ready_i) fsm_q <= SB_IDLE;
        end
        default: fsm_q <= SB_IDLE;
      endcase
    end
  end

  assign bus.ready_o = (fsm_q == SB_IDLE);
  assign bus.valid_o = (fsm_q == SB_DONE);
  assign bus.busy_o  = (fsm_q != SB_IDLE);
  assign bus.state_o = work_q;

endmodule

// File: tb/tb_sub_bytes_stage.sv
// Bench for sub_bytes_stage: one instance per legal LANES value, known vectors plus random traffic.
module tb_sub_bytes_stage;
  import aes_pkg::*;

  localparam int NI = 5;  // instance k uses LANES = 1 << k

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v_i [NI];
  logic       r_i [NI];
  aes_state_t s_i [NI];
  logic       r_o [NI];
  logic       v_o [NI];
  logic       b_o [NI];
  aes_state_t s_o [NI];

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    sub_bytes_stage_if bus ();
    assign bus.valid_i = v_i[g];
    assign bus.state_i = s_i[g];
    assign bus.ready_i = r_i[g];
    assign r_o[g] = bus.ready_o;
    assign v_o[g] = bus.valid_o;
    assign b_o[g] = bus.busy_o;
    assign s_o[g] = bus.state_o;

    sub_bytes_stage #(.LANES(1 << g)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
    );
  end

  int checks = 0;
  int errors = 0;
  aes_byte_t sbox_tab [256];

  typedef struct {
    int         k;
    aes_state_t in;
    aes_state_t exp;
    string      name;
  } vec_t;

  vec_t vecs [8];

  // Reference: polynomial product reduced modulo 0x11b.
  function automatic aes_byte_t gmul_ref(aes_byte_t a, aes_byte_t b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // S-box from its definition: brute-force inverse, then the bitwise affine transform.
  task automatic build_table();
    aes_byte_t x, inv, o;
    logic [7:0] c;
    c = 8'h63;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul_ref(x, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        o[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
             ^ inv[(i + 7) % 8] ^ c[i];
      sbox_tab[v] = o;
    end
  endtask

  function automatic aes_state_t model_state(aes_state_t in);
    aes_state_t o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox_tab[in[8*k +: 8]];
    return o;
  endfunction

  // Literal written byte0-first becomes a state with byte0 in the low bits.
  function automatic aes_state_t rev_bytes(aes_state_t in);
    aes_state_t o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = in[8*(15-k) +: 8];
    return o;
  endfunction

  function automatic aes_state_t rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int groups(int k);
    return 16 >> k;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(int k, string tag);
    chk($sformatf("%s ready_o[%0d]", tag, k), 128'(r_o[k]), 128'(1));
    chk($sformatf("%s valid_o[%0d]", tag, k), 128'(v_o[k]), 128'(0));
    chk($sformatf("%s busy_o[%0d]", tag, k), 128'(b_o[k]), 128'(0));
    chk($sformatf("%s state_o[%0d]", tag, k), s_o[k], 128'(0));
  endtask

  task automatic wait_ready(int k, string tag);
    int n;
    n = 0;
    while (!r_o[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready wait"}, 128'(r_o[k]), 128'(1));
  endtask

  task automatic run_vec(int k, aes_state_t in, aes_state_t exp, string name);
    int lat;
    wait_ready(k, name);
    s_i[k] = in;
    v_i[k] = 1'b1;
    @(negedge clk);
    v_i[k] = 1'b0;
    s_i[k] = ~in;  // input must not be re-read after accept
    lat = 0;
    while (!v_o[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 128'(lat), 128'(groups(k)));
    chk({name, " data"}, s_o[k], exp);
    r_i[k] = 1'b1;
    @(negedge clk);
    r_i[k] = 1'b0;
    chk({name, " valid drop"}, 128'(v_o[k]), 128'(0));
    chk({name, " ready back"}, 128'(r_o[k]), 128'(1));
  endtask

  task automatic reset_mid_op();
    aes_state_t a;
    bit seen0, seen2;
    a = rand_state();
    s_i[0] = a;
    s_i[2] = a;
    v_i[0] = 1'b1;
    v_i[2] = 1'b1;
    @(negedge clk);
    v_i[0] = 1'b0;
    v_i[2] = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset k0 busy", 128'(b_o[0]), 128'(1));
    chk("pre-reset k2 done", 128'(v_o[2]), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs(0, "async reset RUN");
    chk_idle_outputs(2, "async reset DONE");
    @(negedge clk);
    rst_n = 1'b1;
    seen0 = 1'b0;
    seen2 = 1'b0;
    r_i[2] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (v_o[0]) seen0 = 1'b1;
      if (v_o[2]) seen2 = 1'b1;
    end
    r_i[2] = 1'b0;
    chk("no valid after reset k0", 128'(seen0), 128'(0));
    chk("no valid after reset k2", 128'(seen2), 128'(0));
  endtask

  task automatic backpressure();
    aes_state_t a, b, exp;
    int n;
    a = rand_state();
    b = rand_state();
    exp = model_state(a);
    wait_ready(2, "bp");
    s_i[2] = a;
    v_i[2] = 1'b1;
    @(negedge clk);
    v_i[2] = 1'b0;
    n = 0;
    while (!v_o[2] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp first data", s_o[2], exp);
    for (int c = 0; c < 10; c++) begin
      v_i[2] = c[0];
      s_i[2] = b ^ 128'(c);
      @(negedge clk);
      chk($sformatf("bp hold valid %0d", c), 128'(v_o[2]), 128'(1));
      chk($sformatf("bp hold data %0d", c), s_o[2], exp);
    end
    v_i[2] = 1'b0;
    r_i[2] = 1'b1;
    @(negedge clk);
    r_i[2] = 1'b0;
    chk("bp drained", 128'(v_o[2]), 128'(0));
    @(negedge clk);
    chk("bp no stale accept", 128'(b_o[2]), 128'(0));
  endtask

  task automatic back_to_back();
    aes_state_t ins [3];
    int acc [3];
    int nin, nout;
    bit prev_v;
    for (int i = 0; i < 3; i++) ins[i] = rand_state();
    nin = 0;
    nout = 0;
    prev_v = 1'b0;
    r_i[2] = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (v_o[2]) begin
        if (prev_v) chk("b2b valid pulse width", 128'(2), 128'(1));
        if (nout < 3) chk($sformatf("b2b out %0d", nout), s_o[2], model_state(ins[nout]));
        nout++;
      end
      prev_v = v_o[2];
      if (nin < 3) begin
        v_i[2] = 1'b1;
        s_i[2] = ins[nin];
        if (r_o[2]) begin
          acc[nin] = cyc;
          nin++;
        end
      end else begin
        v_i[2] = 1'b0;
      end
      @(negedge clk);
    end
    v_i[2] = 1'b0;
    r_i[2] = 1'b0;
    chk("b2b accepted", 128'(nin), 128'(3));
    chk("b2b outputs", 128'(nout), 128'(3));
    chk("b2b spacing 0-1", 128'(acc[1] - acc[0]), 128'(groups(2) + 2));
    chk("b2b spacing 1-2", 128'(acc[2] - acc[1]), 128'(groups(2) + 2));
  endtask

  task automatic random_run(int k, int nstates, int budget);
    aes_state_t q [$];
    aes_state_t s;
    int got, cyc;
    bit vin, rin;
    got = 0;
    cyc = 0;
    while (got < nstates && cyc < budget) begin
      chk($sformatf("rnd%0d ready&valid", k), 128'(r_o[k] & v_o[k]), 128'(0));
      chk($sformatf("rnd%0d busy", k), 128'(b_o[k]), 128'(!r_o[k]));
      if (v_o[k]) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd%0d unexpected valid_o: state %h with empty scoreboard", k, s_o[k]);
        end else begin
          chk($sformatf("rnd%0d data %0d", k, got), s_o[k], q[0]);
        end
      end
      rin = ($urandom_range(0, 3) != 0);
      if (v_o[k] && rin) begin
        if (q.size() > 0) void'(q.pop_front());
        got++;
      end
      vin = ($urandom_range(0, 1) == 1);
      s = rand_state();
      if (vin && r_o[k]) q.push_back(model_state(s));
      v_i[k] = vin;
      s_i[k] = s;
      r_i[k] = rin;
      @(negedge clk);
      cyc++;
    end
    v_i[k] = 1'b0;
    r_i[k] = 1'b0;
    chk($sformatf("rnd%0d completed states", k), 128'(got), 128'(nstates));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      v_i[k] = 1'b0;
      r_i[k] = 1'b0;
      s_i[k] = '0;
    end
    build_table();

    vecs[0] = '{2, rev_bytes(128'h000153ff000000000000000000000000),
                rev_bytes(128'h637ced16636363636363636363636363), "single bytes L4"};
    vecs[1] = '{2, rev_bytes(128'h000102030405060708090a0b0c0d0e0f),
                rev_bytes(128'h637c777bf26b6fc53001672bfed7ab76), "row0 L4"};
    for (int k = 0; k < NI; k++)
      vecs[2 + k] = '{k, rev_bytes(128'h193de3bea0f4e22b9ac68d2ae9f84808),
                      rev_bytes(128'hd42711aee0bf98f1b8b45de51e415230),
                      $sformatf("fips L%0d", 1 << k)};
    vecs[7] = '{0, rev_bytes(128'h000102030405060708090a0b0c0d0e0f),
                rev_bytes(128'h637c777bf26b6fc53001672bfed7ab76), "row0 L1"};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) chk_idle_outputs(k, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i].k, vecs[i].in, vecs[i].exp, vecs[i].name);

    reset_mid_op();
    backpressure();
    back_to_back();

    random_run(2, 1000, 40000);
    random_run(0, 40, 4000);
    random_run(1, 40, 4000);
    random_run(3, 40, 4000);
    random_run(4, 40, 4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
